// File: rtl/history_detector.sv
`default_nettype none
// ============================================================================
// Module   : history_detector
// Purpose  : Serial history detector. Samples a 1-bit input under an enable,
//            keeps a DEPTH-bit history, and raises a registered one-cycle
//            match pulse when the history equals PATTERN. Overlapping and
//            non-overlapping matches are supported. It also flags runs of
//            consecutive ones and keeps a saturating match counter.
// Ports    : clk         - clock; all state updates on the rising edge
//            reset       - synchronous active-low reset
//            a           - serial data bit
//            en          - sample strobe; a is consumed only when en==1
//            overlap     - 1 = overlapping matches, 0 = non-overlapping
//            clr_count   - synchronous clear of match_count
//            x           - registered one-cycle match pulse
//            y           - registered run flag (run of ones >= RUN_LEN)
//            match_count - saturating count of matches
// Revision : 1.0 - initial parametrised release
// ============================================================================
module history_detector #(
  parameter int               DEPTH   = 4,
  parameter logic [DEPTH-1:0] PATTERN = 4'b1011,
  parameter int               RUN_LEN = 3,
  parameter int               COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a,
  input  logic               en,
  input  logic               overlap,
  input  logic               clr_count,
  output logic               x,
  output logic               y,
  output logic [COUNT_W-1:0] match_count
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int RUN_W  = $clog2(RUN_LEN + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(RUN_LEN);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("history_detector: DEPTH must be at least 2");
    end
    if (RUN_LEN < 1) begin : g_bad_run_len
      $error("history_detector: RUN_LEN must be at least 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } state_e;

  logic [DEPTH-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [RUN_W-1:0]   run_q,  run_d;
  logic               x_q,    x_d;
  logic               y_q,    y_d;
  logic [COUNT_W-1:0] cnt_q,  cnt_d;

  state_e             state;
  logic [DEPTH-1:0]   nh;
  logic               match;
  logic [COUNT_W-1:0] cnt_base;

  // State register: the FSM state is carried by the fill counter itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      run_q  <= '0;
      x_q    <= 1'b0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      run_q  <= run_d;
      x_q    <= x_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    state    = (fill_q == FILL_FULL) ? ARMED : FILLING;
    nh       = {hist_q[DEPTH-2:0], a};
    hist_d   = hist_q;
    fill_d   = fill_q;
    run_d    = run_q;
    y_d      = y_q;
    x_d      = 1'b0;
    match    = 1'b0;

    if (en) begin
      hist_d = nh;
      // The completing bit counts: one short of full is enough.
      match  = (nh == PATTERN) && ((state == ARMED) || (fill_q == FILL_LAST));

      if (match) begin
        // Non-overlapping mode forgets the matched bits entirely.
        fill_d = overlap ? FILL_FULL : '0;
      end else if (state == FILLING) begin
        fill_d = fill_q + FILL_W'(1);
      end

      if (a) begin
        run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
      end else begin
        run_d = '0;
      end

      y_d = (run_d == RUN_MAX);
      x_d = match;
    end

    // Clear first, then count, so a clear coinciding with a match yields 1.
    cnt_base = clr_count ? '0 : cnt_q;
    cnt_d    = (match && (cnt_base != {COUNT_W{1'b1}})) ? cnt_base + COUNT_W'(1)
                                                        : cnt_base;
  end

  assign x           = x_q;
  assign y           = y_q;
  assign match_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_history_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_history_detector
// Purpose  : Self-checking bench for history_detector. Two instances share
//            the stimulus: one with default parameters and one with a 2-bit
//            match counter to reach saturation quickly. A behavioural model
//            keeps the valid sample stream in a queue and derives the
//            expected outputs from it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_history_detector;

  localparam int         DEPTH   = 4;
  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int         RUN_LEN = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a = 1'b0;
  logic       en = 1'b0;
  logic       overlap = 1'b1;
  logic       clr_count = 1'b0;
  logic       x8, y8, x2, y2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit q[$];
  int run_m  = 0;
  int cnt8_m = 0;
  int cnt2_m = 0;
  bit x_m    = 1'b0;
  bit y_m    = 1'b0;

  always #5 clk = ~clk;

  history_detector #(.DEPTH(DEPTH), .PATTERN(PATTERN), .RUN_LEN(RUN_LEN), .COUNT_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .a(a), .en(en), .overlap(overlap),
    .clr_count(clr_count), .x(x8), .y(y8), .match_count(cnt8)
  );

  history_detector #(.DEPTH(DEPTH), .PATTERN(PATTERN), .RUN_LEN(RUN_LEN), .COUNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .a(a), .en(en), .overlap(overlap),
    .clr_count(clr_count), .x(x2), .y(y2), .match_count(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: the last DEPTH valid samples are compared with the pattern.
  task automatic model_edge(input bit ra, input bit ren, input bit rov,
                            input bit rclr, input bit rrst);
    bit hit;
    int w;
    hit = 1'b0;
    if (!rrst) begin
      q.delete();
      run_m  = 0;
      cnt8_m = 0;
      cnt2_m = 0;
      x_m    = 1'b0;
      y_m    = 1'b0;
      return;
    end
    if (ren) begin
      q.push_back(ra);
      if (q.size() > DEPTH) void'(q.pop_front());
      if (q.size() == DEPTH) begin
        w = 0;
        foreach (q[i]) w = w * 2 + int'(q[i]);
        hit = (w == int'(PATTERN));
      end
      run_m = ra ? ((run_m + 1 > RUN_LEN) ? RUN_LEN : run_m + 1) : 0;
      y_m   = (run_m == RUN_LEN);
      if (hit && !rov) q.delete();
    end
    x_m = hit;
    if (rclr) begin
      cnt8_m = 0;
      cnt2_m = 0;
    end
    if (hit) begin
      if (cnt8_m < 255) cnt8_m++;
      if (cnt2_m < 3)   cnt2_m++;
    end
  endtask

  task automatic step(input bit ra, input bit ren, input bit rov,
                      input bit rclr, input bit rrst);
    a         = ra;
    en        = ren;
    overlap   = rov;
    clr_count = rclr;
    reset     = rrst;
    @(posedge clk);
    model_edge(ra, ren, rov, rclr, rrst);
    #1;
    check("x",      {31'd0, x8},  {31'd0, x_m});
    check("y",      {31'd0, y8},  {31'd0, y_m});
    check("count8", {24'd0, cnt8}, cnt8_m);
    check("x_c2",   {31'd0, x2},  {31'd0, x_m});
    check("count2", {30'd0, cnt2}, cnt2_m);
  endtask

  // Feed a list of bits as consecutive samples.
  task automatic feed(input logic [15:0] bits, input int n, input bit rov);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, rov, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset dominates en, a and clr_count.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("reset_x", {31'd0, x8}, 32'd0);
    check("reset_count", {24'd0, cnt8}, 32'd0);

    // Basic match and the pulse falling afterwards.
    feed(16'b1011, 4, 1'b1);
    check("basic_match", {31'd0, x8}, 32'd1);
    check("basic_count", {24'd0, cnt8}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("basic_drop", {31'd0, x8}, 32'd0);

    // Overlapping versus non-overlapping on the same stream.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    feed(16'b1011011, 7, 1'b1);
    check("ovl_count", {24'd0, cnt8}, 32'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b1011011, 7, 1'b0);
    check("novl_count", {24'd0, cnt8}, 32'd1);

    // Enable gaps hold the history.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    feed(16'b10, 2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    feed(16'b11, 2, 1'b1);
    check("gap_match", {31'd0, x8}, 32'd1);

    // Run flag.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    feed(16'b1111, 4, 1'b1);
    check("run_hold", {31'd0, y8}, 32'd1);
    feed(16'b0, 1, 1'b1);
    check("run_drop", {31'd0, y8}, 32'd0);
    feed(16'b10110, 5, 1'b1);

    // Counter saturation, clear with simultaneous match.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    feed(16'b1011011011011011, 16, 1'b1);
    feed(16'b011, 3, 1'b1);
    check("sat_count2", {30'd0, cnt2}, 32'd3);
    feed(16'b01, 2, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_match", {30'd0, cnt2}, 32'd1);

    // Reset in mid-stream discards partial history.
    feed(16'b101, 3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    feed(16'b1, 1, 1'b1);
    check("reset_mid", {31'd0, x8}, 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 99) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
